// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and fills the IF/ID register.
// Optional fetch-address alignment check is enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned STARTUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_excp_adel
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_WAIT  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    if_pc_q, if_pc_d;
    logic [XLEN-1:0]    if_inst_q, if_inst_d;
    logic               if_valid_q, if_valid_d;
    logic               rom_ce_q, rom_ce_d;
`ifdef IF_ALIGN_CHECK_EN
    logic               excp_q, excp_d;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: startup delay before the first fetch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(STARTUP_CYCLES)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_RESET;
        endcase
    end

    // Output/datapath: PC update and IF/ID capture, priority flush > stall > (misalign) > branch > sequential
    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
`ifdef IF_ALIGN_CHECK_EN
        excp_d     = excp_q;
`endif
        if (state_q == S_RUN) begin
            if (flush) begin
                pc_d       = new_pc;
                if_pc_d    = '0;
                if_inst_d  = '0;
                if_valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
                excp_d     = 1'b0;
`endif
            end else if (stall_if) begin
                pc_d = pc_q;
            end else begin
`ifdef IF_ALIGN_CHECK_EN
                if (pc_q[1:0] != 2'b00) begin
                    // Misaligned fetch: report once per capture and park the PC until a flush
                    if_pc_d    = pc_q;
                    if_inst_d  = '0;
                    if_valid_d = 1'b1;
                    excp_d     = 1'b1;
                end else
`endif
                begin
                    if_pc_d    = pc_q;
                    if_inst_d  = rom_inst;
                    if_valid_d = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
                    excp_d     = 1'b0;
`endif
                    pc_d       = branch_flag ? branch_target : pc_q + XLEN'(4);
                end
            end
        end
`ifdef IF_ALIGN_CHECK_EN
        rom_ce_d = (state_d == S_RUN) && (pc_d[1:0] == 2'b00);
`else
        rom_ce_d = (state_d == S_RUN);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
            rom_ce_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            rom_ce_q   <= rom_ce_d;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excp_q <= 1'b0;
        end else begin
            excp_q <= excp_d;
        end
    end
    assign if_excp_adel = excp_q;
`else
    assign if_excp_adel = 1'b0;
`endif

    assign rom_ce   = rom_ce_q;
    assign rom_addr = pc_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: table of per-edge vectors with a queued scoreboard plus reset corner sequences.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if, flush, branch_flag;
    logic [31:0] new_pc, branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;
    logic [31:0] if_pc, if_inst;
    logic        if_valid, if_excp_adel;

    int tests_run = 0;
    int tests_failed = 0;

    if_fetch_unit #(.RESET_PC(32'h0), .STARTUP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target), .rom_ce(rom_ce),
        .rom_addr(rom_addr), .rom_inst(rom_inst), .if_pc(if_pc), .if_inst(if_inst),
        .if_valid(if_valid), .if_excp_adel(if_excp_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0)      return 32'h3401_1100;
        else if (w == 32'h4) return 32'h3402_0020;
        else                 return 32'h1000_0000 | w;
    endfunction

    always_comb rom_inst = rom_ce ? rom_fn(rom_addr) : 32'h0;

    typedef struct {
        logic        fl, st, br;
        logic [31:0] tgt, npc;
        logic [31:0] e_pc, e_inst;
        logic        e_valid, e_excp, e_ce;
        logic [31:0] e_addr;
    } row_t;

    typedef struct {
        logic [31:0] e_pc, e_inst;
        logic        e_valid, e_excp, e_ce;
        logic [31:0] e_addr;
    } exp_t;

    exp_t sb[$];

    function automatic row_t mk(input logic fl, st, br, input logic [31:0] tgt, npc,
                                input logic [31:0] e_pc, e_inst, input logic e_valid,
                                input logic [31:0] e_addr);
        row_t r;
        r.fl = fl; r.st = st; r.br = br; r.tgt = tgt; r.npc = npc;
        r.e_pc = e_pc; r.e_inst = e_inst; r.e_valid = e_valid;
        r.e_excp = 1'b0; r.e_ce = 1'b1; r.e_addr = e_addr;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input row_t r);
        exp_t e;
        @(negedge clk);
        flush = r.fl; stall_if = r.st; branch_flag = r.br;
        branch_target = r.tgt; new_pc = r.npc;
        sb.push_back('{r.e_pc, r.e_inst, r.e_valid, r.e_excp, r.e_ce, r.e_addr});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            e = sb.pop_front();
            check("if_pc", if_pc, e.e_pc);
            check("if_inst", if_inst, e.e_inst);
            check("if_valid", 32'(if_valid), 32'(e.e_valid));
            check("if_excp_adel", 32'(if_excp_adel), 32'(e.e_excp));
            check("rom_ce", 32'(rom_ce), 32'(e.e_ce));
            check("rom_addr", rom_addr, e.e_addr);
        end
    endtask

    row_t tbl[14];
    row_t r;

    initial begin
        tbl[0]  = mk(0,0,0, 0, 0,            32'h0,         32'h3401_1100, 1, 32'h4);
        tbl[1]  = mk(0,0,0, 0, 0,            32'h4,         32'h3402_0020, 1, 32'h8);
        tbl[2]  = mk(0,1,0, 0, 0,            32'h4,         32'h3402_0020, 1, 32'h8);
        tbl[3]  = mk(0,1,0, 0, 0,            32'h4,         32'h3402_0020, 1, 32'h8);
        tbl[4]  = mk(0,1,0, 0, 0,            32'h4,         32'h3402_0020, 1, 32'h8);
        tbl[5]  = mk(0,0,0, 0, 0,            32'h8,         32'h1000_0008, 1, 32'hC);
        tbl[6]  = mk(0,0,0, 0, 0,            32'hC,         32'h1000_000C, 1, 32'h10);
        tbl[7]  = mk(0,0,1, 32'h40, 0,       32'h10,        32'h1000_0010, 1, 32'h40);
        tbl[8]  = mk(0,0,0, 0, 0,            32'h40,        32'h1000_0040, 1, 32'h44);
        tbl[9]  = mk(1,1,1, 32'h80, 32'h20,  32'h0,         32'h0,         0, 32'h20);
        tbl[10] = mk(0,0,0, 0, 0,            32'h20,        32'h1000_0020, 1, 32'h24);
        tbl[11] = mk(1,0,0, 0, 32'hFFFF_FFFC,32'h0,         32'h0,         0, 32'hFFFF_FFFC);
        tbl[12] = mk(0,0,0, 0, 0,            32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h0);
        tbl[13] = mk(0,0,0, 0, 0,            32'h0,         32'h3401_1100, 1, 32'h4);

        rst = 1'b1; stall_if = 0; flush = 0; branch_flag = 0; new_pc = 0; branch_target = 0;
        #12;
        check("reset rom_ce", 32'(rom_ce), 32'h0);
        check("reset rom_addr", rom_addr, 32'h0);
        check("reset if_pc", if_pc, 32'h0);
        check("reset if_inst", if_inst, 32'h0);
        check("reset if_valid", 32'(if_valid), 32'h0);
        check("reset if_excp_adel", 32'(if_excp_adel), 32'h0);

        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("startup edge1 rom_ce", 32'(rom_ce), 32'h0);
        @(posedge clk); #1;
        check("startup edge2 rom_ce", 32'(rom_ce), 32'h1);
        check("startup edge2 rom_addr", rom_addr, 32'h0);
        check("startup edge2 if_valid", 32'(if_valid), 32'h0);

        for (int i = 0; i < 14; i++) step(tbl[i]);

`ifdef IF_ALIGN_CHECK_EN
        r = mk(0,0,1, 32'h42, 0, 32'h4, 32'h3402_0020, 1, 32'h42); r.e_ce = 1'b0; step(r);
        r = mk(0,0,0, 0, 0, 32'h42, 32'h0, 1, 32'h42); r.e_ce = 1'b0; r.e_excp = 1'b1; step(r);
        r = mk(0,0,1, 32'h80, 0, 32'h42, 32'h0, 1, 32'h42); r.e_ce = 1'b0; r.e_excp = 1'b1; step(r);
        r = mk(1,0,0, 0, 32'h100, 32'h0, 32'h0, 0, 32'h100); step(r);
        r = mk(0,0,0, 0, 0, 32'h100, 32'h1000_0100, 1, 32'h104); step(r);
`endif

        // Mid-operation reset clears everything immediately
        @(negedge clk); #2 rst = 1'b1; #1;
        check("midreset rom_ce", 32'(rom_ce), 32'h0);
        check("midreset if_valid", 32'(if_valid), 32'h0);
        check("midreset if_pc", if_pc, 32'h0);
        check("midreset rom_addr", rom_addr, 32'h0);

        // Control inputs are ignored during startup
        @(negedge clk);
        rst = 1'b0; flush = 1; new_pc = 32'h200; stall_if = 1; branch_flag = 1; branch_target = 32'h300;
        @(posedge clk); #1;
        check("wait rom_ce", 32'(rom_ce), 32'h0);
        check("wait rom_addr", rom_addr, 32'h0);
        @(posedge clk); #1;
        check("run rom_addr", rom_addr, 32'h0);
        check("run if_valid", 32'(if_valid), 32'h0);
        step(mk(0,0,0, 0, 0, 32'h0, 32'h3401_1100, 1, 32'h4));

        if (sb.size() != 0) begin
            tests_run++; tests_failed++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the 5-stage core: owns the PC and drives the instruction ROM's chip-enable and byte address.
- Captures the combinational ROM word into the IF/ID pipeline register.
- Handles stall from ctrl, branch redirect from ID (MIPS delay-slot semantics), and flush/exception redirect from ctrl.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- STARTUP_CYCLES, 1, cycles rom_ce stays low after reset release before the first fetch (legal range 1..15).

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- stall_if  input  1  ctrl: hold PC and IF/ID register.
- flush  input  1  ctrl: exception/eret redirect.
- new_pc  input  32  redirect target, valid with flush.
- branch_flag  input  1  ID: taken branch/jump this cycle.
- branch_target  input  32  ID: branch target, valid with branch_flag.
- rom_ce  output  1  ROM chip enable (1 = enabled).
- rom_addr  output  32  ROM byte address (equals pc).
- rom_inst  input  32  ROM data, combinational from rom_addr/rom_ce.
- if_pc  output  32  IF/ID: PC of the captured instruction.
- if_inst  output  32  IF/ID: captured instruction word.
- if_valid  output  1  IF/ID: captured word is a real fetch (0 = bubble).
- if_excp_adel  output  1  IF/ID: fetch address error (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - State S_RESET; pc=RESET_PC; startup counter=0.
  - rom_ce=0; if_pc=0, if_inst=0, if_valid=0, if_excp_adel=0.
- States:
  - S_RESET → S_WAIT on the first clk edge with rst=0.
  - S_WAIT counts clk edges; → S_RUN when the count reaches STARTUP_CYCLES.
  - rom_ce=0 in S_RESET and S_WAIT; rom_ce=1 only in S_RUN.
- rom_addr = pc (registered), every cycle regardless of state.
- Latency: one cycle. The word for pc is on rom_inst in the same cycle and is captured into if_pc/if_inst at the next rising edge.
- Per-edge action in S_RUN, priority flush > stall_if > branch_flag > sequential:
  - flush: pc←new_pc; if_valid←0, if_inst←0, if_pc←0, if_excp_adel←0 (bubble). Flush beats a simultaneous stall.
  - stall_if: pc and all if_* outputs hold.
  - branch_flag: if_pc←pc, if_inst←rom_inst, if_valid←1 (the delay-slot word is kept); pc←branch_target.
  - otherwise: if_pc←pc, if_inst←rom_inst, if_valid←1; pc←pc+4.
- In S_RESET/S_WAIT:
  - IF/ID outputs stay at reset values.
  - flush, stall_if and branch_flag are ignored.
  - pc stays RESET_PC.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- rst asserted mid-operation: immediate return to reset values. Any in-flight fetch is discarded.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - In S_RUN with pc[1:0]≠0 and no flush/stall, rom_ce=0 that cycle.
  - The edge captures if_pc←pc, if_inst←0, if_valid←1, if_excp_adel←1.
  - pc holds until a flush arrives.
  - if_excp_adel clears on the next capture of an aligned fetch or on flush.
- Undefined:
  - pc[1:0] is not checked; rom_ce follows state only.
  - if_excp_adel is tied to 0.
  - Misaligned targets fetch the word at pc with bits [1:0] ignored by the ROM.

Test Plan:
- Reset release, RESET_PC=0, STARTUP_CYCLES=1, ROM words 0x34011100, 0x34020020 → rom_ce=0 for the first edge. Next cycle rom_addr=0x0. After one more edge: if_pc=0x0, if_inst=0x34011100, if_valid=1. Then if_pc=0x4, if_inst=0x34020020.
- stall_if=1 for 3 cycles at pc=0x8 → rom_addr stays 0x8 and if_pc/if_inst unchanged for 3 edges. Fetch resumes at 0x8 on release.
- branch_flag=1, branch_target=0x40 while pc=0x10 → next edge: if_pc=0x10 (delay slot, if_valid=1) and rom_addr=0x40. Following edge: if_pc=0x40.
- flush=1, new_pc=0x20, with stall_if=1 and branch_flag=1 at the same edge → next edge: if_valid=0, if_inst=0, rom_addr=0x20.
- pc=0xFFFF_FFFC, sequential → capture if_pc=0xFFFF_FFFC; then rom_addr=0x0000_0000.
- With IF_ALIGN_CHECK_EN: branch_target=0x42 → the cycle after the delay slot has rom_ce=0. Next edge: if_excp_adel=1, if_pc=0x42, if_inst=0. pc holds until flush new_pc=0x100, then if_excp_adel=0.
